// File: rtl/tx_sample_pacer.sv
// Paces TX FIFO words into the modem TX datapath: one pull per (gap+1) cycles at most,
// either free-running or started by a soft/external sync edge; counts underruns.
module tx_sample_pacer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned GAP_W       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned UR_CNT_W    = 8
) (
    input  logic                i_sys_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic [GAP_W-1:0]    i_tx_sample_gap,
    input  logic                i_sync_type,
    input  logic                i_soft_sync,
    input  logic                i_ext_sync,
    input  logic                i_fifo_empty,
    input  logic [DATA_W-1:0]   i_fifo_data,
    output logic                o_fifo_pull,
    output logic [DATA_W-1:0]   o_sample_data,
    output logic                o_sample_valid,
    input  logic                i_sample_ready,
    output logic [1:0]          o_state,
    output logic [UR_CNT_W-1:0] o_underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [UR_CNT_W-1:0] UR_MAX = '1;

    state_t                  r_state;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [UR_CNT_W-1:0]     r_underrun_cnt;
    logic [DATA_W-1:0]       r_sample_data;
    logic                    r_sample_valid;
    logic [SYNC_STAGES-1:0]  r_ext_sync;
    logic                    r_ext_sync_d;
    logic                    r_soft_d;

    logic                    w_ext_edge;
    logic                    w_soft_edge;
    logic                    w_sync_edge;
    logic                    w_slot;
    logic                    w_pull;

    // External pin is asynchronous: synchronize before edge detection
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ext_sync   <= '0;
            r_ext_sync_d <= 1'b0;
            r_soft_d     <= 1'b0;
        end else begin
            r_ext_sync   <= {r_ext_sync[SYNC_STAGES-2:0], i_ext_sync};
            r_ext_sync_d <= r_ext_sync[SYNC_STAGES-1];
            r_soft_d     <= i_soft_sync;
        end
    end

    assign w_ext_edge  = r_ext_sync[SYNC_STAGES-1] & ~r_ext_sync_d;
    assign w_soft_edge = i_soft_sync & ~r_soft_d;
    assign w_sync_edge = w_ext_edge | w_soft_edge;

    // Output register is free when empty or being drained this cycle
    assign w_slot = ~r_sample_valid | i_sample_ready;
    assign w_pull = (r_state == ST_RUN) & i_enable & w_slot & ~i_fifo_empty;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_gap_cnt      <= '0;
            r_underrun_cnt <= '0;
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            if (w_pull) begin
                r_sample_data  <= i_fifo_data;
                r_sample_valid <= 1'b1;
            end else if (r_sample_valid && i_sample_ready) begin
                r_sample_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    // Sync edges arriving here are intentionally dropped
                    if (i_enable) begin
                        r_underrun_cnt <= '0;
                        r_state        <= i_sync_type ? ST_ARMED : ST_RUN;
                    end
                end
                ST_ARMED: begin
                    if (!i_enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_sync_edge) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!i_enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_slot) begin
                        if (!i_fifo_empty) begin
                            if (i_tx_sample_gap != '0) begin
                                r_gap_cnt <= i_tx_sample_gap;
                                r_state   <= ST_GAP;
                            end
                        end else if (r_underrun_cnt != UR_MAX) begin
                            r_underrun_cnt <= r_underrun_cnt + UR_CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (!i_enable) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                        if (r_gap_cnt == GAP_W'(1)) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_fifo_pull    = w_pull;
    assign o_sample_data  = r_sample_data;
    assign o_sample_valid = r_sample_valid;
    assign o_state        = r_state;
    assign o_underrun_cnt = r_underrun_cnt;

endmodule
